warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
- Collects per-SIMD-core kernel launch requests (thread count + starting PC) into a small request buffer.
- On `launch_kernel`, dispatches one buffered request per cycle as a warp descriptor (`kernel_t`) with an allocated warp ID.
- Tracks which warp IDs are in flight and frees them when the execution side reports completion on `finished_warp_id`.
- Sits between the host/command front end and the SIMD cores.

Parameters:
- NUM_SIMD_CORES, 4, number of request slots (one per core input lane)
- THREAD_COUNT, 8, threads per warp; width of the thread mask
- LOG2_THREAD_COUNT, 3, width of each thread-count field
- NUM_WARPS, 8, warp IDs available for allocation (0..NUM_WARPS-1, must be ≤15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- launch_kernel  in  1  request one dispatch this cycle
- num_incoming_threads  in  [NUM_SIMD_CORES] x LOG2_THREAD_COUNT  per-lane thread count; 0 = no request
- starting_pc  in  [NUM_SIMD_CORES] x 32  per-lane starting PC
- finished_warp_id  in  4  warp ID that completed; 4'hF = none
- valid_kernel  out  1  kernel_out holds a newly dispatched warp (one-cycle pulse)
- kernel_out  out  kernel_t  dispatched warp descriptor

Behaviour:
- Reset (rst low, async): all request slots empty; all warp IDs free; valid_kernel=0; kernel_out all-zero.
- kernel_t fields:
  - warp_id[3:0]
  - pc[31:0]
  - num_threads[LOG2_THREAD_COUNT-1:0]
  - thread_mask[THREAD_COUNT-1:0], equal to (1<<num_threads)-1, so lower num_threads bits are set.
- Slot load: at each rising edge, for each lane i with num_incoming_threads[i]!=0 and slot i empty, capture {starting_pc[i], num_incoming_threads[i]} and mark the slot full.
  - Occupied slots are never overwritten.
  - Lanes with count 0 are ignored.
- Dispatch conditions, all evaluated at a rising edge using pre-edge state:
  - launch_kernel=1,
  - at least one slot full,
  - at least one warp ID free.
- Dispatch actions when the conditions hold:
  - Select the lowest-index full slot and allocate the lowest-index free warp ID.
  - Register kernel_out with that slot's fields and valid_kernel=1; both are visible on the cycle after the edge (1-cycle latency).
  - Clear the slot and mark the warp ID busy.
- When no dispatch occurs: valid_kernel=0 and kernel_out holds its last value.
- launch_kernel held high dispatches one warp per cycle until slots or free warp IDs run out.
- Launch with all slots empty, or all IDs busy: no dispatch, no error; the request is not remembered.
- Clear vs. load: a slot cleared by dispatch at an edge is not reloaded at that same edge. It reloads at a later edge if its lane still presents a nonzero count; upstream must drop the count to 0 after the slot is taken.
- Free: at a rising edge, if finished_warp_id < NUM_WARPS, mark that ID free. 4'hF or an out-of-range value is a no-op; freeing an already-free ID is a no-op.
- Free and allocate in the same edge: the freed ID is not eligible for allocation until the next edge.
- Reset asserted mid-operation discards all buffered requests and in-flight state immediately.

Decomposition:
- Shared package (Structs_and_Params):
  - NUM_SIMD_CORES, THREAD_COUNT, LOG2_THREAD_COUNT, NUM_WARPS
  - kernel_t typedef
  - constant NO_WARP = 4'hF
- Natural sub-module: warp_id_allocator.
  - Holds the free/busy bitmap and a lowest-free priority encoder.
  - Has alloc and free ports and outputs any_free and the allocated ID.
- The slot buffer and slot priority select stay in warp_scheduler.

Test Plan:
- Reset: rst=0 → valid_kernel=0, kernel_out=0. Release rst and launch with no inputs → valid_kernel remains 0.
- Single dispatch:
  - Load lanes 0..3 = {4, FFFF_FFFE}, {2, 8765_4321}, {7, ABCD_EF01}, {0, 0}, then pulse launch_kernel for 1 cycle.
  - Next cycle: valid_kernel=1 with warp_id=0, pc=FFFF_FFFE, num_threads=4, thread_mask=8'h0F.
  - Following cycle: valid_kernel=0.
- Held launch, same loads with inputs zeroed after capture:
  - Cycle 1: warp 0, pc 8765_4321? No — order is slot0 then slot1 then slot2.
  - Warps dispatch as warp 0 pc FFFF_FFFE, warp 1 pc 8765_4321 mask 8'h03, warp 2 pc ABCD_EF01 mask 8'h7F.
  - Fourth cycle: valid_kernel=0 (lane 3 never loaded).
- ID exhaustion: dispatch NUM_WARPS warps; the next launch gives no dispatch. Set finished_warp_id=3 for one cycle, then launch → warp_id=3.
- Same-edge free and allocate:
  - With all IDs busy, assert finished_warp_id=5 and launch_kernel together → no dispatch that edge.
  - Next launch → warp_id=5.
  - finished_warp_id=4'hF causes no state change.
- Async reset mid-run: with slots full and warps busy, drop rst between clock edges → outputs clear immediately. After release, launch dispatches warp_id=0 only once new requests are loaded.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | warp_scheduler_pkg : shared parameters and warp descriptor type            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package warp_scheduler_pkg;

    localparam int NUM_SIMD_CORES    = 4;
    localparam int THREAD_COUNT      = 8;
    localparam int LOG2_THREAD_COUNT = 3;
    localparam int NUM_WARPS         = 8;
    localparam int WARP_ID_W         = 4;

    localparam logic [WARP_ID_W-1:0] NO_WARP = 4'hF;

    typedef struct packed {
        logic [WARP_ID_W-1:0]         warp_id;
        logic [31:0]                  pc;
        logic [LOG2_THREAD_COUNT-1:0] num_threads;
        logic [THREAD_COUNT-1:0]      thread_mask;
    } kernel_t;

    // Lower n bits set; n never reaches THREAD_COUNT because the field is log2-wide.
    function automatic logic [THREAD_COUNT-1:0] thread_mask_of(
        input logic [LOG2_THREAD_COUNT-1:0] n
    );
        return (THREAD_COUNT'(1) << n) - THREAD_COUNT'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/warp_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | warp_scheduler_if : launch request / warp dispatch bundle                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface warp_scheduler_if;
    import warp_scheduler_pkg::*;

    logic                         launch_kernel;
    logic [LOG2_THREAD_COUNT-1:0] num_incoming_threads [NUM_SIMD_CORES];
    logic [31:0]                  starting_pc          [NUM_SIMD_CORES];
    logic [WARP_ID_W-1:0]         finished_warp_id;
    logic                         valid_kernel;
    kernel_t                      kernel_out;

    modport master (
        output launch_kernel, num_incoming_threads, starting_pc, finished_warp_id,
        input  valid_kernel, kernel_out
    );

    modport slave (
        input  launch_kernel, num_incoming_threads, starting_pc, finished_warp_id,
        output valid_kernel, kernel_out
    );

endinterface
`default_nettype wire

// File: rtl/warp_scheduler_warp_id_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | warp_id_allocator : busy bitmap with lowest-free-ID priority encoder       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module warp_id_allocator
    import warp_scheduler_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 alloc,
    input  wire logic [WARP_ID_W-1:0] free_id,
    output logic                      any_free,
    output logic [WARP_ID_W-1:0]      alloc_id
);

    localparam int IDX_W = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0] r_busy;
    logic [NUM_WARPS-1:0] w_busy_next;
    logic                 w_free_ok;

    // Encoder looks only at pre-edge state, so an ID freed this edge waits a cycle.
    always_comb begin
        any_free = 1'b0;
        alloc_id = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                any_free = 1'b1;
                alloc_id = WARP_ID_W'(i);
            end
        end
    end

    assign w_free_ok = (free_id < WARP_ID_W'(NUM_WARPS));

    always_comb begin
        w_busy_next = r_busy;
        if (w_free_ok) begin
            w_busy_next[free_id[IDX_W-1:0]] = 1'b0;
        end
        if (alloc && any_free) begin
            w_busy_next[alloc_id[IDX_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | warp_scheduler : buffers per-lane launch requests, dispatches warps        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module warp_scheduler
    import warp_scheduler_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    warp_scheduler_if.slave sif
);

    localparam int SLOT_IDX_W = $clog2(NUM_SIMD_CORES);

    logic [NUM_SIMD_CORES-1:0]    r_slot_full;
    logic [31:0]                  r_slot_pc  [NUM_SIMD_CORES];
    logic [LOG2_THREAD_COUNT-1:0] r_slot_cnt [NUM_SIMD_CORES];
    logic                         r_valid;
    kernel_t                      r_kernel;

    logic                         w_any_slot;
    logic [SLOT_IDX_W-1:0]        w_sel;
    logic                         w_any_free;
    logic [WARP_ID_W-1:0]         w_alloc_id;
    logic                         w_dispatch;

    always_comb begin
        w_any_slot = 1'b0;
        w_sel      = '0;
        for (int i = NUM_SIMD_CORES - 1; i >= 0; i--) begin
            if (r_slot_full[i]) begin
                w_any_slot = 1'b1;
                w_sel      = SLOT_IDX_W'(i);
            end
        end
    end

    assign w_dispatch = sif.launch_kernel && w_any_slot && w_any_free;

    warp_id_allocator u_alloc (
        .clk      (clk),
        .rst      (rst),
        .alloc    (w_dispatch),
        .free_id  (sif.finished_warp_id),
        .any_free (w_any_free),
        .alloc_id (w_alloc_id)
    );

    // A slot emptied by dispatch was full pre-edge, so it cannot also load this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_full <= '0;
            r_valid     <= 1'b0;
            r_kernel    <= '0;
            for (int i = 0; i < NUM_SIMD_CORES; i++) begin
                r_slot_pc[i]  <= '0;
                r_slot_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SIMD_CORES; i++) begin
                if (w_dispatch && (w_sel == SLOT_IDX_W'(i))) begin
                    r_slot_full[i] <= 1'b0;
                end else if (!r_slot_full[i] && (sif.num_incoming_threads[i] != '0)) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot_pc[i]   <= sif.starting_pc[i];
                    r_slot_cnt[i]  <= sif.num_incoming_threads[i];
                end
            end
            r_valid <= w_dispatch;
            if (w_dispatch) begin
                r_kernel.warp_id     <= w_alloc_id;
                r_kernel.pc          <= r_slot_pc[w_sel];
                r_kernel.num_threads <= r_slot_cnt[w_sel];
                r_kernel.thread_mask <= thread_mask_of(r_slot_cnt[w_sel]);
            end
        end
    end

    assign sif.valid_kernel = r_valid;
    assign sif.kernel_out   = r_kernel;

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_warp_scheduler : directed + random bench against a behavioural model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   cmp_en;

    warp_scheduler_if sif ();

    warp_scheduler dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: request slots and busy IDs as plain arrays, expected outputs.
    bit          m_full [NUM_SIMD_CORES];
    logic [31:0] m_pc   [NUM_SIMD_CORES];
    int          m_cnt  [NUM_SIMD_CORES];
    bit          m_busy [NUM_WARPS];
    bit          exp_valid;
    kernel_t     exp_k;

    function automatic kernel_t mk(input int id, input logic [31:0] pc, input int n,
                                   input logic [7:0] mask);
        kernel_t k;
        k.warp_id     = 4'(id);
        k.pc          = pc;
        k.num_threads = 3'(n);
        k.thread_mask = mask;
        return k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_SIMD_CORES; i++) begin
            m_full[i] = 0; m_pc[i] = '0; m_cnt[i] = 0;
        end
        for (int i = 0; i < NUM_WARPS; i++) m_busy[i] = 0;
        exp_valid = 0;
        exp_k     = '0;
    endtask

    task automatic model_edge();
        int s;
        int w;
        int fid;
        bit disp;
        bit was_full [NUM_SIMD_CORES];
        s = -1;
        w = -1;
        for (int i = 0; i < NUM_SIMD_CORES; i++) begin
            was_full[i] = m_full[i];
            if (m_full[i] && s < 0) s = i;
        end
        for (int i = 0; i < NUM_WARPS; i++) if (!m_busy[i] && w < 0) w = i;
        disp = sif.launch_kernel && (s >= 0) && (w >= 0);
        exp_valid = disp;
        if (disp) begin
            exp_k     = mk(w, m_pc[s], m_cnt[s], 8'((1 << m_cnt[s]) - 1));
            m_full[s] = 0;
        end
        for (int i = 0; i < NUM_SIMD_CORES; i++) begin
            if (!was_full[i] && sif.num_incoming_threads[i] != 0) begin
                m_full[i] = 1;
                m_pc[i]   = sif.starting_pc[i];
                m_cnt[i]  = int'(sif.num_incoming_threads[i]);
            end
        end
        fid = int'(sif.finished_warp_id);
        if (fid < NUM_WARPS) m_busy[fid] = 0;
        if (disp) m_busy[w] = 1;
    endtask

    // One clock: the model steps on the same edge the DUT does; returns at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic set_lane(input int i, input int n, input logic [31:0] pc);
        sif.num_incoming_threads[i] = 3'(n);
        sif.starting_pc[i]          = pc;
    endtask

    task automatic zero_lanes();
        for (int i = 0; i < NUM_SIMD_CORES; i++) set_lane(i, 0, 32'h0);
    endtask

    task automatic std_lanes();
        set_lane(0, 4, 32'hFFFF_FFFE);
        set_lane(1, 2, 32'h8765_4321);
        set_lane(2, 7, 32'hABCD_EF01);
        set_lane(3, 0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (sif.valid_kernel !== exp_valid) begin
                errors++;
                $display("FAIL model_valid @%0t: got %b expected %b", $time, sif.valid_kernel, exp_valid);
            end
            checks++;
            if (sif.kernel_out !== exp_k) begin
                errors++;
                $display("FAIL model_kernel @%0t: got %h expected %h", $time, sif.kernel_out, exp_k);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 0;
        rst    = 1'b0;
        sif.launch_kernel    = 1'b0;
        sif.finished_warp_id = NO_WARP;
        zero_lanes();
        model_reset();

        #3;
        chk("reset_valid", 64'(sif.valid_kernel), 64'd0);
        chk("reset_kernel", 64'(sif.kernel_out), 64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1;

        sif.launch_kernel = 1'b1;
        tick();
        chk("empty_launch", 64'(sif.valid_kernel), 64'd0);
        sif.launch_kernel = 1'b0;

        // Single dispatch
        std_lanes();
        tick();
        zero_lanes();
        sif.launch_kernel = 1'b1;
        tick();
        chk("single_valid", 64'(sif.valid_kernel), 64'd1);
        chk("single_kernel", 64'(sif.kernel_out), 64'(mk(0, 32'hFFFF_FFFE, 4, 8'h0F)));
        sif.launch_kernel = 1'b0;
        tick();
        chk("single_pulse", 64'(sif.valid_kernel), 64'd0);

        // Held launch: free warp 0 while reloading lane 0
        std_lanes();
        sif.finished_warp_id = 4'd0;
        tick();
        zero_lanes();
        sif.finished_warp_id = NO_WARP;
        sif.launch_kernel    = 1'b1;
        tick();
        chk("held_k0", 64'(sif.kernel_out), 64'(mk(0, 32'hFFFF_FFFE, 4, 8'h0F)));
        tick();
        chk("held_k1", 64'(sif.kernel_out), 64'(mk(1, 32'h8765_4321, 2, 8'h03)));
        tick();
        chk("held_k2", 64'(sif.kernel_out), 64'(mk(2, 32'hABCD_EF01, 7, 8'h7F)));
        tick();
        chk("held_done", 64'(sif.valid_kernel), 64'd0);
        sif.launch_kernel = 1'b0;

        // ID exhaustion
        set_lane(0, 1, 32'h100); set_lane(1, 3, 32'h200);
        set_lane(2, 5, 32'h300); set_lane(3, 6, 32'h400);
        tick();
        zero_lanes();
        sif.launch_kernel = 1'b1;
        for (int i = 3; i < 7; i++) begin
            tick();
            chk("exh_id", 64'(sif.kernel_out.warp_id), 64'(i));
        end
        sif.launch_kernel = 1'b0;
        set_lane(1, 1, 32'h500);
        tick();
        zero_lanes();
        sif.launch_kernel = 1'b1;
        tick();
        chk("exh_id7", 64'(sif.kernel_out.warp_id), 64'd7);
        sif.launch_kernel = 1'b0;
        set_lane(0, 2, 32'h1000);
        tick();
        zero_lanes();
        sif.launch_kernel = 1'b1;
        tick();
        chk("exh_none", 64'(sif.valid_kernel), 64'd0);
        sif.launch_kernel    = 1'b0;
        sif.finished_warp_id = 4'd3;
        tick();
        sif.finished_warp_id = NO_WARP;
        sif.launch_kernel    = 1'b1;
        tick();
        chk("reuse_3", 64'(sif.kernel_out), 64'(mk(3, 32'h1000, 2, 8'h03)));
        chk("reuse_3_valid", 64'(sif.valid_kernel), 64'd1);
        sif.launch_kernel = 1'b0;

        // Same-edge free and allocate
        set_lane(0, 3, 32'h2000);
        tick();
        zero_lanes();
        sif.finished_warp_id = 4'd5;
        sif.launch_kernel    = 1'b1;
        tick();
        chk("same_edge_none", 64'(sif.valid_kernel), 64'd0);
        sif.finished_warp_id = NO_WARP;
        tick();
        chk("same_edge_next", 64'(sif.kernel_out), 64'(mk(5, 32'h2000, 3, 8'h07)));
        sif.launch_kernel = 1'b0;
        set_lane(0, 1, 32'h3000);
        tick();
        zero_lanes();
        sif.launch_kernel = 1'b1;
        tick();
        chk("no_warp_noop", 64'(sif.valid_kernel), 64'd0);
        sif.launch_kernel = 1'b0;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_SIMD_CORES; i++)
                set_lane(i, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 7)) : 0, $urandom);
            sif.launch_kernel    = ($urandom_range(0, 2) != 0);
            sif.finished_warp_id = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NO_WARP;
            tick();
        end

        // Async reset between edges
        sif.launch_kernel    = 1'b0;
        sif.finished_warp_id = NO_WARP;
        std_lanes();
        set_lane(3, 1, 32'h4444);
        tick();
        zero_lanes();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 64'(sif.valid_kernel), 64'd0);
        chk("async_kernel", 64'(sif.kernel_out), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sif.launch_kernel = 1'b1;
        tick();
        chk("post_reset_empty", 64'(sif.valid_kernel), 64'd0);
        sif.launch_kernel = 1'b0;
        set_lane(2, 5, 32'h1234_5678);
        tick();
        zero_lanes();
        sif.launch_kernel = 1'b1;
        tick();
        chk("post_reset_k", 64'(sif.kernel_out), 64'(mk(0, 32'h1234_5678, 5, 8'h1F)));
        sif.launch_kernel = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
